// File: rtl/cic_comb_decimator.sv
// CIC decimator back end: keeps every R-th valid integrator sample and applies
// one comb stage y = x[n] - x[n-M] in WIDTH-bit modular arithmetic.
module cic_comb_decimator #(
  parameter int WIDTH = 8,
  parameter int R     = 4,
  parameter int M     = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] x,
  input  logic             in_valid,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  output logic             primed
);

  localparam int PW = (R > 1) ? $clog2(R) : 1;
  localparam int CW = $clog2(M + 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(R - 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(M);

  logic [PW-1:0]    phase_q, phase_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dly_q [M];
  logic [WIDTH-1:0] y_q, y_d;
  logic             y_valid_q;
  logic             primed_q, primed_d;
  logic             sample_evt;

  // With R == 1 the phase counter is stuck at 0, so every valid cycle samples.
  assign sample_evt = in_valid && (phase_q == PHASE_LAST);

  always_comb begin
    phase_d = phase_q;
    if (in_valid) begin
      phase_d = sample_evt ? '0 : phase_q + PW'(1);
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    primed_d = primed_q;
    y_d      = y_q;
    if (sample_evt) begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CW'(1);
      end else begin
        primed_d = 1'b1;
      end
      // Modular difference: integrator wrap-around cancels here.
      y_d = x - dly_q[M-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      phase_q   <= '0;
      cnt_q     <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      primed_q  <= 1'b0;
      for (int i = 0; i < M; i++) begin
        dly_q[i] <= '0;
      end
    end else begin
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      y_q       <= y_d;
      y_valid_q <= sample_evt;
      primed_q  <= primed_d;
      if (sample_evt) begin
        dly_q[0] <= x;
        for (int i = 1; i < M; i++) begin
          dly_q[i] <= dly_q[i-1];
        end
      end
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign primed  = primed_q;

endmodule

// File: tb/tb_cic_comb_decimator.sv
// Directed bench for cic_comb_decimator: three instances cover (R=4,M=1),
// (R=1,M=2) and (R=4,M=2); expected values are hand-computed or modelled here.
module tb_cic_comb_decimator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic       a_rstn, a_in_valid, a_y_valid, a_primed;
  logic [7:0] a_x, a_y;
  logic       b_rstn, b_in_valid, b_y_valid, b_primed;
  logic [7:0] b_x, b_y;
  logic       c_rstn, c_in_valid, c_y_valid, c_primed;
  logic [7:0] c_x, c_y;

  cic_comb_decimator #(.WIDTH(8), .R(4), .M(1)) dut_a (
    .clk(clk), .rstn(a_rstn), .x(a_x), .in_valid(a_in_valid),
    .y(a_y), .y_valid(a_y_valid), .primed(a_primed)
  );

  cic_comb_decimator #(.WIDTH(8), .R(1), .M(2)) dut_b (
    .clk(clk), .rstn(b_rstn), .x(b_x), .in_valid(b_in_valid),
    .y(b_y), .y_valid(b_y_valid), .primed(b_primed)
  );

  cic_comb_decimator #(.WIDTH(8), .R(4), .M(2)) dut_c (
    .clk(clk), .rstn(c_rstn), .x(c_x), .in_valid(c_in_valid),
    .y(c_y), .y_valid(c_y_valid), .primed(c_primed)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_a;
    a_rstn = 1'b0; a_in_valid = 1'b0; a_x = 8'd0;
    tick();
    a_rstn = 1'b1;
  endtask

  task automatic test_reset;
    a_rstn = 1'b0; b_rstn = 1'b0; c_rstn = 1'b0;
    a_in_valid = 1'b1; b_in_valid = 1'b1; c_in_valid = 1'b1;
    a_x = 8'h55; b_x = 8'h55; c_x = 8'h55;
    tick();
    tick();
    vectors++;
    if (a_y !== 8'd0 || a_y_valid !== 1'b0 || a_primed !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_a: got y=%0d v=%b p=%b expected y=0 v=0 p=0", a_y, a_y_valid, a_primed);
    end
    vectors++;
    if (b_y !== 8'd0 || b_y_valid !== 1'b0 || b_primed !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_b: got y=%0d v=%b p=%b expected y=0 v=0 p=0", b_y, b_y_valid, b_primed);
    end
    vectors++;
    if (c_y !== 8'd0 || c_y_valid !== 1'b0 || c_primed !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_c: got y=%0d v=%b p=%b expected y=0 v=0 p=0", c_y, c_y_valid, c_primed);
    end
    a_rstn = 1'b1; b_rstn = 1'b1; c_rstn = 1'b1;
    a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0;
  endtask

  // Continuous in_valid, x = start, start+1, ...; strobe after every 4th sample.
  task automatic run_stream(input string name, input logic [7:0] start,
                            input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2);
    logic [7:0] exp_y [3];
    logic       exp_p [3];
    logic [7:0] last_y;
    logic       exp_v;
    int         k;
    exp_y = '{e0, e1, e2};
    exp_p = '{1'b0, 1'b1, 1'b1};
    last_y = 8'd0;
    k = 0;
    reset_a();
    for (int i = 0; i < 12; i++) begin
      a_x = start + 8'(i);
      a_in_valid = 1'b1;
      tick();
      exp_v = ((i % 4) == 3);
      vectors++;
      if (a_y_valid !== exp_v) begin
        miscompares++;
        $display("FAIL %s_valid[%0d]: got %b expected %b", name, i, a_y_valid, exp_v);
      end
      if (exp_v) begin
        vectors++;
        if (a_y !== exp_y[k] || a_primed !== exp_p[k]) begin
          miscompares++;
          $display("FAIL %s_out[%0d]: got y=%0d p=%b expected y=%0d p=%b",
                   name, k, a_y, a_primed, exp_y[k], exp_p[k]);
        end
        last_y = exp_y[k];
        k++;
      end else begin
        vectors++;
        if (a_y !== last_y) begin
          miscompares++;
          $display("FAIL %s_hold[%0d]: got y=%0d expected %0d", name, i, a_y, last_y);
        end
      end
    end
    a_in_valid = 1'b0;
  endtask

  task automatic test_continuous;
    run_stream("cont", 8'd0, 8'd3, 8'd4, 8'd4);
  endtask

  task automatic test_wrap;
    run_stream("wrap", 8'd248, 8'd251, 8'd4, 8'd4);
  endtask

  task automatic test_gaps;
    logic [7:0] exp_y [3];
    int n, k, last_strobe;
    logic exp_v;
    exp_y = '{8'd3, 8'd4, 8'd4};
    n = 0; k = 0; last_strobe = -1;
    reset_a();
    for (int c = 0; c < 24; c++) begin
      if (c % 2 == 0) begin
        a_in_valid = 1'b1; a_x = 8'(n); n++;
      end else begin
        a_in_valid = 1'b0; a_x = 8'hAA;
      end
      tick();
      exp_v = (c % 2 == 0) && (((n - 1) % 4) == 3);
      vectors++;
      if (a_y_valid !== exp_v) begin
        miscompares++;
        $display("FAIL gaps_valid[%0d]: got %b expected %b", c, a_y_valid, exp_v);
      end
      if (exp_v) begin
        vectors++;
        if (a_y !== exp_y[k]) begin
          miscompares++;
          $display("FAIL gaps_out[%0d]: got y=%0d expected %0d", k, a_y, exp_y[k]);
        end
        if (last_strobe >= 0) begin
          vectors++;
          if (a_y_valid && (c - last_strobe) != 8) begin
            miscompares++;
            $display("FAIL gaps_spacing[%0d]: got %0d expected 8", k, c - last_strobe);
          end
        end
        if (a_y_valid) last_strobe = c;
        k++;
      end
    end
    a_in_valid = 1'b0;
  endtask

  task automatic test_r1m2;
    logic [7:0] xs    [5];
    logic [7:0] exp_y [5];
    logic       exp_p [5];
    xs    = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50};
    exp_y = '{8'd10, 8'd20, 8'd20, 8'd20, 8'd20};
    exp_p = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    b_rstn = 1'b0; b_in_valid = 1'b0;
    tick();
    b_rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b_x = xs[i];
      b_in_valid = 1'b1;
      tick();
      vectors++;
      if (b_y_valid !== 1'b1 || b_y !== exp_y[i] || b_primed !== exp_p[i]) begin
        miscompares++;
        $display("FAIL r1m2_out[%0d]: got v=%b y=%0d p=%b expected v=1 y=%0d p=%b",
                 i, b_y_valid, b_y, b_primed, exp_y[i], exp_p[i]);
      end
    end
    b_in_valid = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic exp_v;
    reset_a();
    for (int i = 0; i < 6; i++) begin
      a_x = 8'(i); a_in_valid = 1'b1;
      tick();
    end
    a_rstn = 1'b0; a_x = 8'd6; a_in_valid = 1'b1;
    tick();
    vectors++;
    if (a_y !== 8'd0 || a_y_valid !== 1'b0 || a_primed !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_clear: got y=%0d v=%b p=%b expected y=0 v=0 p=0",
               a_y, a_y_valid, a_primed);
    end
    a_rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_x = 8'(100 + i); a_in_valid = 1'b1;
      tick();
      exp_v = (i == 3);
      vectors++;
      if (a_y_valid !== exp_v || a_y !== (exp_v ? 8'd103 : 8'd0) || a_primed !== 1'b0) begin
        miscompares++;
        $display("FAIL midreset_restart[%0d]: got v=%b y=%0d p=%b expected v=%b y=%0d p=0",
                 i, a_y_valid, a_y, a_primed, exp_v, exp_v ? 103 : 0);
      end
    end
    a_in_valid = 1'b0;
  endtask

  task automatic test_random;
    logic [7:0] s [$];
    logic [7:0] exp_y, last_y;
    logic       exp_v, exp_p;
    int         vcount, k;
    vcount = 0; last_y = 8'd0;
    c_rstn = 1'b0; c_in_valid = 1'b0;
    tick();
    c_rstn = 1'b1;
    for (int i = 0; i < 48; i++) begin
      c_x = 8'($urandom_range(0, 255));
      c_in_valid = 1'b1;
      tick();
      vcount++;
      exp_v = ((vcount % 4) == 0);
      vectors++;
      if (c_y_valid !== exp_v) begin
        miscompares++;
        $display("FAIL rand_valid[%0d]: got %b expected %b", i, c_y_valid, exp_v);
      end
      if (exp_v) begin
        s.push_back(c_x);
        k = s.size() - 1;
        exp_y = s[k] - ((k >= 2) ? s[k-2] : 8'd0);
        exp_p = (k >= 2);
        vectors++;
        if (c_y !== exp_y || c_primed !== exp_p) begin
          miscompares++;
          $display("FAIL rand_out[%0d]: got y=%0d p=%b expected y=%0d p=%b",
                   k, c_y, c_primed, exp_y, exp_p);
        end
        last_y = exp_y;
      end else begin
        vectors++;
        if (c_y !== last_y) begin
          miscompares++;
          $display("FAIL rand_hold[%0d]: got y=%0d expected %0d", i, c_y, last_y);
        end
      end
    end
    c_in_valid = 1'b0;
  endtask

  initial begin
    a_rstn = 1'b0; a_in_valid = 1'b0; a_x = 8'd0;
    b_rstn = 1'b0; b_in_valid = 1'b0; b_x = 8'd0;
    c_rstn = 1'b0; c_in_valid = 1'b0; c_x = 8'd0;
    test_reset();
    test_continuous();
    test_wrap();
    test_gaps();
    test_r1m2();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
